// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_DSIZE     = 8;

  // Index width for a requester id; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [2*NREQ-1:0] dbl_s;

  assign dbl_s = {req, req};

  // Scan upward from ptr through the doubled vector so the search wraps without a comparator chain.
  always_comb begin
    int pos;
    pos   = 0;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < NREQ; j++) begin
      pos   = int'(ptr) + j;
      idx   = (dbl_s[pos] && !found) ? IW'(pos % NREQ) : idx;
      found = found | dbl_s[pos];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers,
// granting bursts of up to MAX_BURST beats and stalling on wfull.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DSIZE     = DEF_DSIZE,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int IW       = clog2_min1(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            pick_found_s;
  logic [IW-1:0]   pick_idx_s;
  logic            busy_s;
  logic            xfer_s;
  logic [IW-1:0]   next_ptr_s;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  assign busy_s     = (state_q == GRANT);
  assign xfer_s     = busy_s & req_valid[owner_q] & ~wfull;
  assign next_ptr_s = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  // Write-port mux: outputs are forced to zero whenever no beat moves so winc/wdata never carry X.
  always_comb begin
    req_ready = '0;
    if (busy_s && !wfull) begin
      req_ready[owner_q] = 1'b1;
    end else begin
      req_ready = '0;
    end
    winc     = xfer_s;
    wdata    = xfer_s ? req_data[int'(owner_q)*DSIZE +: DSIZE] : '0;
    grant_id = busy_s ? owner_q : '0;
    busy     = busy_s;
  end

  // Next-state: arbitrate in IDLE, count beats in GRANT, release on last, full burst or abandonment.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d    = GRANT;
          owner_d    = pick_idx_s;
          beat_cnt_d = '0;
        end else begin
          state_d    = IDLE;
        end
      end
      GRANT: begin
        if (!req_valid[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr_s;
        end else if (xfer_s) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (req_last[owner_q] || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr_s;
          end else begin
            state_d  = GRANT;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
